// File: rtl/pipelined_mem_responder.sv
// Word-addressed memory responder: one read or write accepted per cycle, with read
// data returned exactly LATENCY cycles after issue through a fixed-depth valid/data pipeline.
module pipelined_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);

    localparam int DEPTH = 2 ** (ADDR_BITS - 1);

    logic [ADDR_BITS-2:0]      word_idx;
    logic                      read_valid;
    logic [15:0]               read_data;
    logic [LATENCY-1:0]        stage_valid;
    logic [LATENCY-1:0][15:0]  stage_data;
    logic                      unused_addr;

    // addr[0] and bits above ADDR_BITS alias onto the same word
    assign word_idx    = addr[ADDR_BITS-1:1];
    assign unused_addr = ^addr;

    // NOTE: storage has no reset; contents must survive rst and a reset would stop it mapping to RAM.
    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && enable && wr)
            mem[word_idx] <= data_in;
    end

    // Snapshot taken at issue, so later writes cannot disturb an in-flight read.
    assign read_valid = enable & ~wr;
    assign read_data  = mem[word_idx];

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        logic        d_valid;
        logic [15:0] d_data;

        if (i == 0) begin : g_head
            assign d_valid = read_valid;
            assign d_data  = read_data;
        end else begin : g_link
            assign d_valid = stage_valid[i-1];
            assign d_data  = stage_data[i-1];
        end

        // NOTE: non-blocking updates let every stage sample its predecessor's old value on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
            end else begin
                stage_valid[i] <= d_valid;
                stage_data[i]  <= d_data;
            end
        end
    end

    assign data_valid = stage_valid[LATENCY-1];
    assign data_out   = stage_valid[LATENCY-1] ? stage_data[LATENCY-1] : 16'h0000;
    assign busy       = |stage_valid;

endmodule

// File: tb/tb_pipelined_mem_responder.sv
// Directed bench for pipelined_mem_responder: latency, throughput, snapshot, reset flush,
// address aliasing (including an ADDR_BITS=8 instance) and a scoreboard-driven mixed run.
module tb_pipelined_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic [15:0] data_out8;
    logic        data_valid8;
    logic        busy8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_mem_responder #(.LATENCY(LAT), .ADDR_BITS(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .busy(busy)
    );

    pipelined_mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out8), .data_valid(data_valid8), .busy(busy8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    // Garbage on wr/addr/data_in while enable=0 must be ignored.
    task automatic idle();
        drive(1'b0, 1'b1, 16'hFFFF, 16'hDEAD);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: data_valid=%b expected 0", data_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        n_checks++;
        if (data_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: data_out=%h expected 0000", data_out);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        logic        ev;
        logic        eb;
        logic [15:0] ed;
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step();
        // read issued at cycle 0 of this loop
        for (int c = 0; c <= 6; c++) begin
            ev = (c == LAT);
            eb = (c >= 1) && (c <= LAT);
            ed = ev ? 16'hBEEF : 16'h0000;
            n_checks++;
            if (data_valid !== ev || busy !== eb || data_out !== ed) begin
                n_fail++;
                $display("FAIL single_read cycle %0d: valid=%b busy=%b data=%h expected valid=%b busy=%b data=%h",
                         c, data_valid, busy, data_out, ev, eb, ed);
            end
            if (c == 0) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
            else        idle();
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic        ev;
        logic        eb;
        logic [15:0] ed;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 16'h0100 + 16'(2 * i), 16'hA000 + 16'(i));
            step();
        end
        idle();
        step();
        for (int c = 0; c <= 13; c++) begin
            ev = (c >= LAT) && (c <= LAT + 7);
            eb = (c >= 1) && (c <= LAT + 7);
            ed = ev ? 16'hA000 + 16'(c - LAT) : 16'h0000;
            n_checks++;
            if (data_valid !== ev || busy !== eb || data_out !== ed) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: valid=%b busy=%b data=%h expected valid=%b busy=%b data=%h",
                         c, data_valid, busy, data_out, ev, eb, ed);
            end
            if (c < 8) drive(1'b1, 1'b0, 16'h0100 + 16'(2 * c), 16'h0000);
            else       idle();
            step();
        end
    endtask

    task automatic test_snapshot();
        logic        ev;
        logic [15:0] ed;
        drive(1'b1, 1'b1, 16'h0020, 16'h1111);
        step();
        for (int c = 0; c <= 11; c++) begin
            ev = (c == LAT) || (c == 6 + LAT);
            ed = (c == LAT) ? 16'h1111 : (c == 6 + LAT) ? 16'h2222 : 16'h0000;
            n_checks++;
            if (data_valid !== ev || data_out !== ed) begin
                n_fail++;
                $display("FAIL snapshot cycle %0d: valid=%b data=%h expected valid=%b data=%h",
                         c, data_valid, data_out, ev, ed);
            end
            case (c)
                0:       drive(1'b1, 1'b0, 16'h0020, 16'h0000);
                1:       drive(1'b1, 1'b1, 16'h0020, 16'h2222);
                6:       drive(1'b1, 1'b0, 16'h0020, 16'h0000);
                default: idle();
            endcase
            step();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic        ev;
        logic [15:0] ed;
        for (int c = 0; c <= 15; c++) begin
            if (c == 2) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rst_burst_busy_before cycle %0d: busy=%b expected 1", c, busy);
                end
            end
            if (c >= 3 && c <= 8) begin
                n_checks++;
                if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL rst_burst_flush cycle %0d: valid=%b busy=%b data=%h expected 0 0 0000",
                             c, data_valid, busy, data_out);
                end
            end
            if (c >= 9 + LAT) begin
                ev = (c <= 10 + LAT);
                ed = (c == 9 + LAT) ? 16'hA000 : (c == 10 + LAT) ? 16'hA001 : 16'h0000;
                n_checks++;
                if (data_valid !== ev || data_out !== ed) begin
                    n_fail++;
                    $display("FAIL rst_burst_reread cycle %0d: valid=%b data=%h expected valid=%b data=%h",
                             c, data_valid, data_out, ev, ed);
                end
            end
            rst = (c == 2);
            case (c)
                0:       drive(1'b1, 1'b0, 16'h0100, 16'h0000);
                1:       drive(1'b1, 1'b0, 16'h0102, 16'h0000);
                2:       drive(1'b1, 1'b1, 16'h0100, 16'hFFFF);
                9:       drive(1'b1, 1'b0, 16'h0100, 16'h0000);
                10:      drive(1'b1, 1'b0, 16'h0102, 16'h0000);
                default: idle();
            endcase
            step();
        end
        rst = 1'b0;
    endtask

    task automatic test_alias();
        drive(1'b1, 1'b1, 16'h0031, 16'h5A5A);
        step();
        for (int c = 0; c <= 6; c++) begin
            if (c == LAT) begin
                n_checks++;
                if (data_valid !== 1'b1 || data_out !== 16'h5A5A) begin
                    n_fail++;
                    $display("FAIL alias_lsb: valid=%b data=%h expected valid=1 data=5a5a", data_valid, data_out);
                end
                n_checks++;
                if (data_valid8 !== 1'b1 || data_out8 !== 16'h5A5A) begin
                    n_fail++;
                    $display("FAIL alias8_lsb: valid=%b data=%h expected valid=1 data=5a5a", data_valid8, data_out8);
                end
            end
            if (c == LAT + 1) begin
                n_checks++;
                if (data_valid8 !== 1'b1 || data_out8 !== 16'h5A5A) begin
                    n_fail++;
                    $display("FAIL alias8_wrap: valid=%b data=%h expected valid=1 data=5a5a", data_valid8, data_out8);
                end
            end
            if (c == 0)      drive(1'b1, 1'b0, 16'h0030, 16'h0000);
            else if (c == 1) drive(1'b1, 1'b0, 16'h0130, 16'h0000);
            else             idle();
            step();
        end
    endtask

    task automatic test_mixed();
        logic [15:0] shadow [8];
        logic        pv [LAT];
        logic [15:0] pd [LAT];
        logic        ev;
        logic        eb;
        logic [15:0] ed;
        logic        nv;
        logic [15:0] nd;
        logic [15:0] a;
        logic [15:0] val;
        int          op;
        int          slot;
        for (int i = 0; i < 8; i++) begin
            shadow[i] = 16'h3C00 + 16'(i * 7);
            drive(1'b1, 1'b1, 16'h0200 + 16'(2 * i), shadow[i]);
            step();
        end
        for (int k = 0; k < LAT; k++) begin
            pv[k] = 1'b0;
            pd[k] = 16'h0000;
        end
        for (int c = 0; c < 200 + LAT; c++) begin
            ev = pv[LAT-1];
            ed = ev ? pd[LAT-1] : 16'h0000;
            eb = 1'b0;
            for (int k = 0; k < LAT; k++) eb = eb | pv[k];
            n_checks++;
            if (data_valid !== ev || busy !== eb || data_out !== ed) begin
                n_fail++;
                $display("FAIL mixed cycle %0d: valid=%b busy=%b data=%h expected valid=%b busy=%b data=%h",
                         c, data_valid, busy, data_out, ev, eb, ed);
            end
            op   = (c < 200) ? int'($urandom_range(0, 2)) : 2;
            slot = int'($urandom_range(0, 7));
            a    = 16'h0200 + 16'(2 * slot) + 16'($urandom_range(0, 1));
            val  = 16'($urandom);
            nv   = 1'b0;
            nd   = 16'h0000;
            case (op)
                0: begin
                    drive(1'b1, 1'b1, a, val);
                    shadow[slot] = val;
                end
                1: begin
                    drive(1'b1, 1'b0, a, val);
                    nv = 1'b1;
                    nd = shadow[slot];
                end
                default: idle();
            endcase
            for (int k = LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[0] = nv;
            pd[0] = nd;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_snapshot();
        test_reset_mid_burst();
        test_alias();
        test_mixed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
